// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the J-type opcode used by the optional jump predecoder and the
// sequential PC increment.
package fetch_pkg;

   // Fetch FSM states (2-bit encoding, values fixed for debug visibility)
   typedef enum logic [1:0] {
      FETCH = 2'd0,  // request pc_r from the instruction cache
      WAIT  = 2'd1,  // request accepted, waiting for the response
      HOLD  = 2'd2,  // instruction buffered, waiting for queue space
      DROP  = 2'd3   // redirected while a response was in flight; discard it
   } fetch_state_t;

   // Primary opcode of the unconditional J instruction (inst[31:26])
   localparam logic [5:0] OPC_J = 6'b000010;

   // Byte distance between sequential instructions
   localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch unit. Always provides pc + 4
// (wrapping modulo 2^ADDR_W). When FETCH_JUMP_PREDECODE_EN is defined, a
// J instruction in the buffer redirects the next fetch to its target
// {pc[31:28], inst[25:0], 2'b00}; otherwise no decode logic exists.
module fetch_next_pc
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] pc_seq;

   // Sequential successor; the adder width makes 0xFFFFFFFC wrap to 0
   assign pc_seq = pc + ADDR_W'(PC_INCR);

`ifdef FETCH_JUMP_PREDECODE_EN
   logic              is_jump;
   logic [ADDR_W-1:0] pc_jump;

   assign is_jump = (inst[31:26] == OPC_J);
   assign pc_jump = {pc[ADDR_W-1:28], inst[25:0], 2'b00};

   // Jump target wins over the sequential PC for J instructions
   always_comb begin
      next_pc = pc_seq;
      if (is_jump) begin
         next_pc = pc_jump;
      end
   end
`else
   // The instruction is not decoded in this build
   logic unused_inst;
   assign unused_inst = ^inst;
   assign next_pc     = pc_seq;
`endif

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage feeding the instruction-queue FIFO.
// Keeps the PC, issues one cache request at a time, buffers the returned
// instruction and writes {pc, instr} into the queue when it is not full.
// Redirects from branch resolution override everything at the clock edge;
// a response still in flight at that moment is discarded in DROP.
//
// Handshakes:
//   cache request : a request is accepted in a cycle where ic_req && ic_ack.
//                   The response (ic_valid) arrives at least one cycle later,
//                   exactly once per accepted request.
//   queue write   : fifo_w_en is a write strobe; it is only raised when
//                   fifo_full is low and no redirect is being taken.
//
// Build option: FETCH_JUMP_PREDECODE_EN enables J-instruction predecode
// in the next-PC selection (see fetch_next_pc).
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     ic_req,
   output logic [ADDR_W-1:0]        ic_addr,
   input  logic                     ic_ack,
   input  logic                     ic_valid,
   input  logic [INST_W-1:0]        ic_data,
   output logic                     fifo_w_en,
   output logic [ADDR_W+INST_W-1:0] fifo_din,
   input  logic                     fifo_full,
   input  logic                     redirect_en,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic [ADDR_W-1:0]        fetch_pc
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc_r;
   logic [INST_W-1:0] inst_r;
   logic              req_r;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] redirect_target;
   logic              req_hit;
   logic              write_fire;

   // Redirect targets are word aligned; the two low bits are ignored
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};

   // A request is only taken by the cache while it is being offered
   assign req_hit = req_r & ic_ack;

   // Queue write: the only combinational path from inputs to outputs.
   // A redirect in the same cycle kills the write of the held instruction.
   assign write_fire = (state == HOLD) & ~fifo_full & ~redirect_en;

   assign ic_req    = req_r;
   assign ic_addr   = pc_r;
   assign fetch_pc  = pc_r;
   assign fifo_w_en = write_fire;
   assign fifo_din  = {pc_r, inst_r};

   fetch_next_pc #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_next_pc (
      .pc      (pc_r),
      .inst    (inst_r),
      .next_pc (pc_next)
   );

   // Fetch FSM: state, PC, instruction buffer and registered request valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= FETCH;
         pc_r   <= RESET_PC;
         inst_r <= '0;
         req_r  <= 1'b0;
      end else if (redirect_en) begin
         pc_r <= redirect_target;
         case (state)
            FETCH: begin
               if (req_hit) begin
                  // Request accepted this very cycle: its response is stale
                  state <= DROP;
                  req_r <= 1'b0;
               end else begin
                  state <= FETCH;
                  req_r <= 1'b1;
               end
            end
            WAIT, DROP: begin
               // A response arriving in the redirect cycle is the stale one
               // and is discarded here; otherwise wait for it in DROP.
               if (ic_valid) begin
                  state <= FETCH;
                  req_r <= 1'b1;
               end else begin
                  state <= DROP;
                  req_r <= 1'b0;
               end
            end
            HOLD: begin
               // The buffered instruction is abandoned
               state <= FETCH;
               req_r <= 1'b1;
            end
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (req_hit) begin
                  state <= WAIT;
                  req_r <= 1'b0;
               end else begin
                  req_r <= 1'b1;
               end
            end
            WAIT: begin
               if (ic_valid) begin
                  inst_r <= ic_data;
                  state  <= HOLD;
               end
            end
            HOLD: begin
               // Stay put with PC and data unchanged while the queue is full
               if (write_fire) begin
                  pc_r  <= pc_next;
                  state <= FETCH;
                  req_r <= 1'b1;
               end
            end
            DROP: begin
               if (ic_valid) begin
                  state <= FETCH;
                  req_r <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
